// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the K580VT57 four-channel DMA controller.
package k580vt57_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned CNTW = 14;

  localparam logic [3:0] REG_MODE = 4'd8;

  localparam int unsigned MODE_ROT    = 4;
  localparam int unsigned MODE_TCSTOP = 6;
  localparam int unsigned MODE_AUTO   = 7;

  typedef enum logic [1:0] {
    XFER_VERIFY  = 2'b00,
    XFER_WRITE   = 2'b01,
    XFER_READ    = 2'b10,
    XFER_VERIFY3 = 2'b11
  } xfer_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4
  } state_t;

  typedef struct packed {
    logic memr_n;
    logic memw_n;
    logic ior_n;
    logic iow_n;
  } strobe_t;

  function automatic logic [1:0] oh2idx(input logic [NCH-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Replace the low or high byte of a 16-bit channel register.
  function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] w, input logic hi,
                                             input logic [DW-1:0] b);
    logic [AW-1:0] r;
    r = w;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

endpackage

// File: rtl/k580vt57_prio.sv
// Channel arbiter: fixed (channel 0 first) or rotating (last served goes lowest).
module k580vt57_prio
  import k580vt57_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [1:0]     last,
  input  logic           rotate,
  output logic [NCH-1:0] grant
);

  logic [1:0] start;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    start = rotate ? last + 2'd1 : 2'd0;
    for (int i = 0; i < NCH; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/k580vt57_dma.sv
// K580VT57 (i8257) compatible DMA controller: CPU register port, arbitration,
// and the S1-S4 memory/I/O transfer sequencer.
module k580vt57_dma
  import k580vt57_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     iaddr,
  input  logic [DW-1:0]  idata,
  output logic [DW-1:0]  odata,
  input  logic           iwe_n,
  input  logic           ird_n,
  input  logic [NCH-1:0] drq,
  output logic [NCH-1:0] dack,
  output logic           hrq,
  input  logic           hlda,
  output logic [AW-1:0]  oaddr,
  output logic           memr_n,
  output logic           memw_n,
  output logic           ior_n,
  output logic           iow_n,
  output logic           tc
);

  state_t state_q, state_d;

  logic [AW-1:0]  addr_q [NCH];
  logic [AW-1:0]  cnt_q  [NCH];
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] tcf_q;
  logic           rot_q, tcstop_q, auto_q, update_q;
  logic           ff_q, we_q, rd_q;
  logic [1:0]     ch_q, last_q;
  xfer_t          typ_q;
  logic           fin_q;

  logic [NCH-1:0] elig, elig_pr, grant;
  logic [1:0]     win, ch_d, rsel;
  logic           stop_ch, wr_edge, rd_edge;
  logic [AW-1:0]  a_win, c_win, a_inc, c_dec, sel_reg;
  xfer_t          typ_d;
  logic           xfer_rd, xfer_wr;

  logic [NCH-1:0] dack_q, dack_d;
  logic           hrq_q, hrq_d, tc_q, tc_d;
  logic [AW-1:0]  oaddr_q, oaddr_d;
  strobe_t        strb_q, strb_d;

  assign elig    = drq & en_q;
  assign stop_ch = fin_q & tcstop_q & ~((ch_q == 2'd2) & auto_q);
  assign elig_pr = (state_q == ST_S4 && stop_ch) ? (elig & ~(NCH'(1) << ch_q)) : elig;
  assign win     = oh2idx(grant);
  assign wr_edge = iwe_n & ~we_q;
  assign rd_edge = ird_n & ~rd_q;
  assign rsel    = iaddr[2:1];
  assign a_inc   = addr_q[ch_q] + AW'(1);
  assign c_dec   = {cnt_q[ch_q][AW-1:CNTW], cnt_q[ch_q][CNTW-1:0] - CNTW'(1)};

  k580vt57_prio u_prio (
    .req    (elig_pr),
    .last   (last_q),
    .rotate (rot_q),
    .grant  (grant)
  );

  // Winner's registers as they will stand after this edge, so back-to-back
  // transfers on the same channel see the S4 increment/reload.
  always_comb begin
    a_win = addr_q[win];
    c_win = cnt_q[win];
    if (state_q == ST_S4 && win == ch_q) begin
      a_win = a_inc;
      c_win = c_dec;
      if (fin_q && ch_q == 2'd2 && auto_q) begin
        a_win = addr_q[3];
        c_win = cnt_q[3];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|elig) state_d = ST_REQ;
      ST_REQ: begin
        if (~|elig)    state_d = ST_IDLE;
        else if (hlda) state_d = ST_S1;
      end
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = ST_S4;
      ST_S4:   state_d = (hlda && |elig_pr) ? ST_S1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ch_d    = (state_d == ST_S1) ? win : ch_q;
    typ_d   = (state_d == ST_S1) ? xfer_t'(c_win[AW-1:CNTW]) : typ_q;
    xfer_rd = (typ_d == XFER_READ);
    xfer_wr = (typ_d == XFER_WRITE);

    hrq_d   = (state_d != ST_IDLE);
    dack_d  = '0;
    if (state_d inside {ST_S1, ST_S2, ST_S3}) dack_d = NCH'(1) << ch_d;

    strb_d = '1;
    if (state_d inside {ST_S2, ST_S3}) begin
      strb_d.memr_n = ~xfer_rd;
      strb_d.ior_n  = ~xfer_wr;
    end
    if (state_d == ST_S3) begin
      strb_d.iow_n  = ~xfer_rd;
      strb_d.memw_n = ~xfer_wr;
    end

    tc_d    = fin_q && (state_d inside {ST_S2, ST_S3, ST_S4});
    oaddr_d = (state_d == ST_S1) ? a_win : oaddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      tc_q    <= 1'b0;
      oaddr_q <= '0;
      strb_q  <= '1;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      dack_q  <= dack_d;
      tc_q    <= tc_d;
      oaddr_q <= oaddr_d;
      strb_q  <= strb_d;
    end
  end

  // Register file, transfer bookkeeping and CPU port; CPU writes land last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      en_q     <= '0;
      tcf_q    <= '0;
      rot_q    <= 1'b0;
      tcstop_q <= 1'b0;
      auto_q   <= 1'b0;
      update_q <= 1'b0;
      ff_q     <= 1'b0;
      we_q     <= 1'b1;
      rd_q     <= 1'b1;
      ch_q     <= '0;
      last_q   <= 2'd3;
      typ_q    <= XFER_VERIFY;
      fin_q    <= 1'b0;
    end else begin
      we_q <= iwe_n;
      rd_q <= ird_n;

      if (state_d == ST_S1) begin
        ch_q  <= win;
        typ_q <= typ_d;
        fin_q <= (c_win[CNTW-1:0] == '0);
        if (rot_q) last_q <= win;
      end
      if (state_q == ST_S1 && ch_q == 2'd2) update_q <= 1'b0;

      if (state_q == ST_S4) begin
        addr_q[ch_q] <= a_inc;
        cnt_q[ch_q]  <= c_dec;
        if (fin_q) begin
          tcf_q[ch_q] <= 1'b1;
          if (stop_ch) en_q[ch_q] <= 1'b0;
          if (ch_q == 2'd2 && auto_q) begin
            addr_q[2] <= addr_q[3];
            cnt_q[2]  <= cnt_q[3];
            update_q  <= 1'b1;
          end
        end
      end

      if (wr_edge) begin
        if (!iaddr[3]) begin
          if (iaddr[0]) begin
            cnt_q[rsel] <= put_byte(cnt_q[rsel], ff_q, idata);
            if (auto_q && rsel == 2'd2) cnt_q[3] <= put_byte(cnt_q[3], ff_q, idata);
          end else begin
            addr_q[rsel] <= put_byte(addr_q[rsel], ff_q, idata);
            if (auto_q && rsel == 2'd2) addr_q[3] <= put_byte(addr_q[3], ff_q, idata);
          end
        end else if (iaddr == REG_MODE) begin
          en_q     <= idata[NCH-1:0];
          rot_q    <= idata[MODE_ROT];
          tcstop_q <= idata[MODE_TCSTOP];
          auto_q   <= idata[MODE_AUTO];
          ff_q     <= 1'b0;
        end
      end

      if (rd_edge && iaddr == REG_MODE) tcf_q <= '0;
      if ((wr_edge || rd_edge) && !iaddr[3]) ff_q <= ~ff_q;
    end
  end

  // CPU read mux.
  always_comb begin
    odata   = '0;
    sel_reg = iaddr[0] ? cnt_q[rsel] : addr_q[rsel];
    if (!iaddr[3])               odata = ff_q ? sel_reg[15:8] : sel_reg[7:0];
    else if (iaddr == REG_MODE)  odata = {3'b000, update_q, tcf_q};
  end

  assign hrq    = hrq_q;
  assign dack   = dack_q;
  assign tc     = tc_q;
  assign oaddr  = oaddr_q;
  assign memr_n = strb_q.memr_n;
  assign memw_n = strb_q.memw_n;
  assign ior_n  = strb_q.ior_n;
  assign iow_n  = strb_q.iow_n;

endmodule

// File: tb/tb_k580vt57_dma.sv
// Directed bench for k580vt57_dma: register port, read/write blocks, priority,
// hlda drop, byte flip-flop and asynchronous reset.
module tb_k580vt57_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iaddr = '0;
  logic [7:0]  idata = '0;
  logic [7:0]  odata;
  logic        iwe_n = 1'b1;
  logic        ird_n = 1'b1;
  logic [3:0]  drq = '0;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda;
  logic [15:0] oaddr;
  logic        memr_n, memw_n, ior_n, iow_n, tc;
  logic        tie = 1'b1;
  logic        hlda_m = 1'b0;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;
  assign hlda = tie ? hrq : hlda_m;

  k580vt57_dma dut (
    .clk(clk), .rst_n(rst_n), .iaddr(iaddr), .idata(idata), .odata(odata),
    .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
    .oaddr(oaddr), .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n),
    .tc(tc)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] strb();
    return {12'h000, memr_n, memw_n, ior_n, iow_n};
  endfunction

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk);
    iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    iaddr = a; ird_n = 1'b0;
    #1 d = odata;
    @(negedge clk);
    ird_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge inside S1 of the next transfer on any channel.
  task automatic wait_any(output logic [3:0] g, output logic ok);
    int n;
    n = 0; ok = 1'b0; g = '0;
    while (!ok && n < 60) begin
      @(negedge clk);
      n++;
      if (|dack) begin ok = 1'b1; g = dack; end
    end
  endtask

  logic [7:0] rd;
  logic [3:0] g;
  logic       ok;
  logic       seen;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_hrq", 16'(hrq), 16'h0);
    chk("rst_strb", strb(), 16'hF);
    chk("rst_dack", 16'(dack), 16'h0);
    chk("rst_tc", 16'(tc), 16'h0);
    chk("rst_oaddr", oaddr, 16'h0);
    rst_n = 1'b1;
    cpu_rd(4'd8, rd);
    chk("rst_status", 16'(rd), 16'h00);

    // 2: channel 2 read block with autoload
    cpu_wr(4'd8, 8'h84);
    cpu_wr(4'd4, 8'hD0);
    cpu_wr(4'd4, 8'h76);
    cpu_wr(4'd5, 8'h4F);
    cpu_wr(4'd5, 8'h80);
    drq = 4'b0100;
    for (int i = 0; i < 80; i++) begin
      wait_any(g, ok);
      if (!ok) begin chk("t2_timeout", 16'(ok), 16'h1); break; end
      chk("t2_dack", 16'(g), 16'h4);
      chk("t2_addr", oaddr, 16'(16'h76D0 + i));
      chk("t2_s1_strb", strb(), 16'hF);
      if (i == 79) drq = 4'b0000;
      @(negedge clk);
      chk("t2_s2_strb", strb(), 16'h7);
      chk("t2_s2_tc", 16'(tc), 16'(i == 79));
      @(negedge clk);
      chk("t2_s3_strb", strb(), 16'h6);
      @(negedge clk);
      chk("t2_s4_strb", strb(), 16'hF);
      chk("t2_s4_dack", 16'(dack), 16'h0);
      chk("t2_s4_tc", 16'(tc), 16'(i == 79));
    end
    @(negedge clk);
    chk("t2_idle_hrq", 16'(hrq), 16'h0);
    cpu_rd(4'd4, rd); chk("t2_a2_lo", 16'(rd), 16'hD0);
    cpu_rd(4'd4, rd); chk("t2_a2_hi", 16'(rd), 16'h76);
    cpu_rd(4'd5, rd); chk("t2_c2_lo", 16'(rd), 16'h4F);
    cpu_rd(4'd5, rd); chk("t2_c2_hi", 16'(rd), 16'h80);
    cpu_rd(4'd8, rd); chk("t2_status", 16'(rd), 16'h14);
    cpu_rd(4'd8, rd); chk("t2_status_clr", 16'(rd), 16'h10);

    // 3: channel 0 write block with TC-stop
    cpu_wr(4'd8, 8'h41);
    cpu_wr(4'd0, 8'h00);
    cpu_wr(4'd0, 8'h10);
    cpu_wr(4'd1, 8'h02);
    cpu_wr(4'd1, 8'h40);
    drq = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      wait_any(g, ok);
      if (!ok) begin chk("t3_timeout", 16'(ok), 16'h1); break; end
      chk("t3_dack", 16'(g), 16'h1);
      chk("t3_addr", oaddr, 16'(16'h1000 + i));
      @(negedge clk);
      chk("t3_s2_strb", strb(), 16'hD);
      @(negedge clk);
      chk("t3_s3_strb", strb(), 16'h9);
      chk("t3_s3_tc", 16'(tc), 16'(i == 2));
      @(negedge clk);
      chk("t3_s4_strb", strb(), 16'hF);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (hrq || |dack) seen = 1'b1;
    end
    chk("t3_stopped", 16'(seen), 16'h0);
    drq = 4'b0000;
    cpu_rd(4'd8, rd); chk("t3_status", 16'(rd), 16'h11);

    // 4: fixed then rotating priority, channels 1 and 3
    cpu_wr(4'd8, 8'h0A);
    cpu_wr(4'd3, 8'h10);
    cpu_wr(4'd3, 8'h80);
    cpu_wr(4'd7, 8'h10);
    cpu_wr(4'd7, 8'h80);
    drq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_any(g, ok);
      if (!ok) begin chk("t4f_timeout", 16'(ok), 16'h1); break; end
      chk("t4_fixed", 16'(g), 16'h2);
      if (i == 3) drq = 4'b0000;
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t4f_idle", 16'(hrq), 16'h0);
    cpu_wr(4'd8, 8'h1A);
    drq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_any(g, ok);
      if (!ok) begin chk("t4r_timeout", 16'(ok), 16'h1); break; end
      chk("t4_rotate", 16'(g), (i % 2 == 0) ? 16'h2 : 16'h8);
      if (i == 3) drq = 4'b0000;
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t4r_idle", 16'(hrq), 16'h0);

    // 5: hlda drops during S2
    tie = 1'b0;
    cpu_wr(4'd8, 8'h01);
    cpu_wr(4'd1, 8'h05);
    cpu_wr(4'd1, 8'h80);
    drq = 4'b0001;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      ok = hrq;
    end
    chk("t5_hrq", 16'(ok), 16'h1);
    hlda_m = 1'b1;
    wait_any(g, ok);
    chk("t5_dack", 16'(g), 16'h1);
    @(negedge clk);
    hlda_m = 1'b0;
    chk("t5_s2_strb", strb(), 16'h7);
    @(negedge clk);
    chk("t5_s3_strb", strb(), 16'h6);
    @(negedge clk);
    chk("t5_s4_strb", strb(), 16'hF);
    @(negedge clk);
    chk("t5_hrq_low", 16'(hrq), 16'h0);
    chk("t5_dack_low", 16'(dack), 16'h0);
    drq = 4'b0000;
    tie = 1'b1;
    cpu_wr(4'd8, 8'h00);
    cpu_rd(4'd1, rd); chk("t5_c0_lo", 16'(rd), 16'h04);
    cpu_rd(4'd1, rd); chk("t5_c0_hi", 16'(rd), 16'h80);

    // 6: byte flip-flop
    cpu_wr(4'd0, 8'h34);
    cpu_wr(4'd0, 8'h12);
    cpu_rd(4'd0, rd); chk("t6_a0_lo", 16'(rd), 16'h34);
    cpu_rd(4'd0, rd); chk("t6_a0_hi", 16'(rd), 16'h12);
    cpu_rd(4'd0, rd); chk("t6_a0_lo2", 16'(rd), 16'h34);
    cpu_wr(4'd8, 8'h00);
    cpu_rd(4'd0, rd); chk("t6_ff_clr", 16'(rd), 16'h34);
    cpu_rd(4'd9, rd); chk("t6_unused", 16'(rd), 16'h00);

    // asynchronous reset in the middle of a transfer
    cpu_wr(4'd8, 8'h01);
    drq = 4'b0001;
    wait_any(g, ok);
    chk("t7_dack", 16'(g), 16'h1);
    @(negedge clk);
    chk("t7_s2_strb", strb(), 16'h7);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_strb", strb(), 16'hF);
    chk("t7_rst_hrq", 16'(hrq), 16'h0);
    chk("t7_rst_dack", 16'(dack), 16'h0);
    chk("t7_rst_oaddr", oaddr, 16'h0);
    drq = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
